// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master and its companion slave.
// CS_GAP is expected to be at least 1.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_CS_GAP     = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    TRANSFER = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake plus SPI wires of one master; the slave modport is the
// view a peripheral on the serial bus takes.
interface spi_master_if #(
  parameter int DATA_WIDTH = spi_pkg::DEFAULT_DATA_WIDTH
);

  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  ready;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic                  cs_bar;

  modport master (
    input  start, tx_data, miso,
    output ready, busy, rx_data, rx_valid, sclk, mosi, cs_bar
  );

  modport slave (
    input  sclk, mosi, cs_bar,
    output miso
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: while enabled, sclk toggles every CLK_DIV cycles starting
// low; rise/fall flag the clk edge on which sclk is about to change.
module spi_sclk_gen #(
  parameter int CLK_DIV = spi_pkg::DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick = en && (div_q == DIV_LAST);
  assign rise = tick && !sclk_q;
  assign fall = tick && sclk_q;
  assign sclk = sclk_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state is written with <= so every flop samples pre-edge values.
    if (reset) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// Companion SPI slave in the master's clock domain: samples mosi and launches
// the next miso bit on each sclk rise; reports the word when cs_bar deasserts.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  spi_master_if.slave           bus
);

  logic                  sclk_prev_q, sclk_prev_d;
  logic                  cs_prev_q, cs_prev_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  sclk_rise, cs_rise;

  assign sclk_rise = bus.sclk && !sclk_prev_q && !bus.cs_bar;
  assign cs_rise   = bus.cs_bar && !cs_prev_q;

  always_comb begin
    sclk_prev_d = bus.sclk;
    cs_prev_d   = bus.cs_bar;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = miso_q;
    if (bus.cs_bar) begin
      tx_sr_d = tx_data;
      miso_d  = 1'b0;
    end else if (sclk_rise) begin
      miso_d  = tx_sr_q[DATA_WIDTH-1];
      tx_sr_d = tx_sr_q << 1;
      rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], bus.mosi};
    end
    if (cs_rise) begin
      rx_data_d  = rx_sr_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
    end
  end

  assign bus.miso = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: rtl/spi_master.sv
// SPI master, CPOL=0: MSB-first frames, mosi launched on sclk rise, miso
// captured on sclk fall, with setup/hold/gap framing around cs_bar.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int CS_GAP     = DEFAULT_CS_GAP
) (
  input  logic clk,
  input  logic reset,
  spi_master_if.master bus
);

  localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam int WAIT_W = $clog2(max_int(CLK_DIV, CS_GAP)) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(CS_GAP - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_bar_q, cs_bar_d;
  logic                  ready_q, ready_d;
  logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

  logic sclk_en, sclk, sclk_rise, sclk_fall;

  assign sclk_en = (state_q == SETUP) || (state_q == TRANSFER);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (sclk_en),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    // NOTE: every _d starts from a default so no branch can infer a latch.
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    cs_bar_d   = cs_bar_q;
    edge_cnt_d = edge_cnt_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_sr_d    = bus.tx_data;
          mosi_d     = bus.tx_data[DATA_WIDTH-1];
          cs_bar_d   = 1'b0;
          edge_cnt_d = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // The MSB is already on mosi, so the first rise only starts the count.
        if (sclk_rise) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          state_d    = TRANSFER;
        end
      end
      TRANSFER: begin
        if (sclk_rise) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          tx_sr_d    = tx_sr_q << 1;
          mosi_d     = tx_sr_d[DATA_WIDTH-1];
        end
        if (sclk_fall) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
          rx_sr_d    = {rx_sr_q[DATA_WIDTH-2:0], bus.miso};
          if (edge_cnt_q == LAST_EDGE) begin
            wait_cnt_d = '0;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (wait_cnt_q == HOLD_LAST) begin
          cs_bar_d   = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_d;
          rx_valid_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (wait_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        cs_bar_d = 1'b1;
        mosi_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      cs_bar_q   <= 1'b1;
      ready_q    <= 1'b1;
      edge_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mosi_q     <= mosi_d;
      cs_bar_q   <= cs_bar_d;
      ready_q    <= ready_d;
      edge_cnt_q <= edge_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.sclk     = sclk;
  assign bus.mosi     = mosi_q;
  assign bus.cs_bar   = cs_bar_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: frame timing, loopback, slave data, busy
// behaviour, back-to-back frames, mid-frame reset and a CLK_DIV=2 link.
module tb_spi_master;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_WIDTH(16)) bus ();
  spi_master_if #(.DATA_WIDTH(16)) bus2 ();

  logic        loop_mode  = 1'b1;
  logic        model_miso = 1'b0;
  logic [15:0] model_sh   = '0;
  logic [15:0] slave_word = '0;
  logic [15:0] slave_tx   = 16'hBEEF;
  logic [15:0] slave_rx;
  logic        slave_rx_valid;

  assign bus.miso = loop_mode ? bus.mosi : model_miso;

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(4), .CS_GAP(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(2), .CS_GAP(4)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  spi_slave #(.DATA_WIDTH(16)) u_slave (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (slave_tx),
    .rx_data  (slave_rx),
    .rx_valid (slave_rx_valid),
    .bus      (bus2)
  );

  // Bus monitor and behavioural slave for the default-parameter master.
  int          cyc = 0;
  logic        sclk_p = 1'b0, cs_p = 1'b1, mosi_p = 1'b0;
  int          rises = 0, falls = 0, bad_mosi = 0;
  int          rxv_cnt = 0, rxv_last = 0, rxv_prev = 0;
  int          high_run = 0, gap_len = 0, srxv_cnt = 0;
  logic [15:0] mosi_seq = '0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sclk_p <= bus.sclk;
    cs_p   <= bus.cs_bar;
    mosi_p <= bus.mosi;
    if (cs_p && !bus.cs_bar) begin
      rises    <= 0;
      falls    <= 0;
      mosi_seq <= '0;
      gap_len  <= high_run;
    end else if (!bus.cs_bar) begin
      if (bus.sclk && !sclk_p) begin
        rises    <= rises + 1;
        mosi_seq <= {mosi_seq[14:0], bus.mosi};
      end
      if (!bus.sclk && sclk_p) falls <= falls + 1;
      if (!cs_p && (bus.mosi != mosi_p) && !(bus.sclk && !sclk_p)) bad_mosi <= bad_mosi + 1;
    end
    if (bus.cs_bar) high_run <= high_run + 1;
    else            high_run <= 0;
    if (bus.rx_valid) begin
      rxv_cnt  <= rxv_cnt + 1;
      rxv_prev <= rxv_last;
      rxv_last <= cyc;
    end
    if (slave_rx_valid) srxv_cnt <= srxv_cnt + 1;
    if (bus.cs_bar) begin
      model_sh   <= slave_word;
      model_miso <= 1'b0;
    end else if (bus.sclk && !sclk_p) begin
      model_miso <= model_sh[15];
      model_sh   <= {model_sh[14:0], 1'b0};
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0;
  int base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge inside cycle T(k) of the current frame.
  task automatic goto(input int k);
    while (cyc < t0 + k) @(negedge clk);
  endtask

  task automatic start_frame(input logic [15:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.start   = 1'b1;
    t0          = cyc;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.tx_data  = '0;
    bus2.start   = 1'b0;
    bus2.tx_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",    32'(bus.ready),    32'd1);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_cs_bar",   32'(bus.cs_bar),   32'd1);
    check("rst_sclk",     32'(bus.sclk),     32'd0);
    check("rst_mosi",     32'(bus.mosi),     32'd0);
    check("rst_rx_data",  32'(bus.rx_data),  32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback frame 0xA5C3 with default timing
    loop_mode = 1'b1;
    start_frame(16'hA5C3);
    check("t1_cs_bar", 32'(bus.cs_bar), 32'd0);
    check("t1_mosi",   32'(bus.mosi),   32'd1);
    check("t1_sclk",   32'(bus.sclk),   32'd0);
    check("t1_busy",   32'(bus.busy),   32'd1);
    check("t1_ready",  32'(bus.ready),  32'd0);
    goto(4);
    check("t4_sclk", 32'(bus.sclk), 32'd0);
    goto(5);
    check("t5_sclk", 32'(bus.sclk), 32'd1);
    goto(128);
    check("t128_sclk", 32'(bus.sclk), 32'd1);
    goto(129);
    check("t129_sclk",   32'(bus.sclk),   32'd0);
    check("t129_cs_bar", 32'(bus.cs_bar), 32'd0);
    goto(132);
    check("t132_cs_bar",   32'(bus.cs_bar),   32'd0);
    check("t132_rx_valid", 32'(bus.rx_valid), 32'd0);
    goto(133);
    check("t133_cs_bar",   32'(bus.cs_bar),   32'd1);
    check("t133_rx_valid", 32'(bus.rx_valid), 32'd1);
    check("t133_rx_data",  32'(bus.rx_data),  32'hA5C3);
    check("t133_mosi",     32'(bus.mosi),     32'd0);
    check("loop_mosi_seq", 32'(mosi_seq),     32'hA5C3);
    goto(134);
    check("t134_rx_valid", 32'(bus.rx_valid), 32'd0);
    goto(136);
    check("t136_ready", 32'(bus.ready), 32'd0);
    goto(137);
    check("t137_ready", 32'(bus.ready), 32'd1);
    check("t137_busy",  32'(bus.busy),  32'd0);

    // Behavioural slave returns 0x1234
    loop_mode  = 1'b0;
    slave_word = 16'h1234;
    start_frame(16'h00FF);
    goto(137);
    check("slv_rx_data", 32'(bus.rx_data), 32'h1234);
    check("slv_rises",   32'(rises),       32'd16);
    check("slv_falls",   32'(falls),       32'd16);
    check("slv_mosi",    32'(mosi_seq),    32'h00FF);

    // start and tx_data activity while busy
    loop_mode = 1'b1;
    base = rxv_cnt;
    start_frame(16'h3C5A);
    goto(40);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    goto(50);
    bus.tx_data = 16'hFFFF;
    goto(145);
    check("busy_rxv_cnt",  32'(rxv_cnt),     32'(base + 1));
    check("busy_cs_bar",   32'(bus.cs_bar),  32'd1);
    check("busy_mosi_seq", 32'(mosi_seq),    32'h3C5A);
    check("busy_rx_data",  32'(bus.rx_data), 32'h3C5A);

    // start held high: three back-to-back frames
    base = rxv_cnt;
    @(negedge clk);
    bus.tx_data = 16'h5AA5;
    bus.start   = 1'b1;
    t0          = cyc;
    goto(137);
    check("b2b_t137_cs_bar", 32'(bus.cs_bar), 32'd1);
    check("b2b_t137_ready",  32'(bus.ready),  32'd1);
    goto(138);
    check("b2b_t138_cs_bar", 32'(bus.cs_bar), 32'd0);
    goto(280);
    bus.start = 1'b0;
    check("b2b_gap_len", 32'(gap_len), 32'd5);
    goto(415);
    check("b2b_rxv_cnt",   32'(rxv_cnt),             32'(base + 3));
    check("b2b_spacing",   32'(rxv_last - rxv_prev), 32'd137);
    check("b2b_last_time", 32'(rxv_last),            32'(t0 + 407));
    check("b2b_rx_data",   32'(bus.rx_data),         32'h5AA5);
    check("b2b_ready",     32'(bus.ready),           32'd1);

    // Reset at T60 aborts the frame
    base = rxv_cnt;
    start_frame(16'h1234);
    goto(60);
    reset = 1'b1;
    goto(61);
    check("rst61_cs_bar", 32'(bus.cs_bar), 32'd1);
    check("rst61_sclk",   32'(bus.sclk),   32'd0);
    check("rst61_ready",  32'(bus.ready),  32'd1);
    reset = 1'b0;
    goto(200);
    check("rst_no_rxv",   32'(rxv_cnt),     32'(base));
    check("rst_ready2",   32'(bus.ready),   32'd1);
    check("rst_rx_clear", 32'(bus.rx_data), 32'd0);
    check("rst_mosi2",    32'(bus.mosi),    32'd0);

    // CLK_DIV=2 master against spi_slave
    @(negedge clk);
    bus2.tx_data = 16'h0F0F;
    bus2.start   = 1'b1;
    t0           = cyc;
    @(negedge clk);
    bus2.start = 1'b0;
    goto(67);
    check("div2_t67_rx_valid", 32'(bus2.rx_valid), 32'd1);
    check("div2_t67_cs_bar",   32'(bus2.cs_bar),   32'd1);
    goto(70);
    check("div2_t70_ready", 32'(bus2.ready), 32'd0);
    goto(71);
    check("div2_t71_ready", 32'(bus2.ready),   32'd1);
    check("div2_master_rx", 32'(bus2.rx_data), 32'hBEEF);
    check("div2_slave_rx",  32'(slave_rx),     32'h0F0F);
    check("div2_slave_rxv", 32'(srxv_cnt),     32'd1);

    check("mosi_stable", 32'(bad_mosi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
